wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Writeback stage directly upstream of the integer register file (REGS).
//  Arbitrates completed results from the ALU path and the load (MEM) path,
//  registers the winner, and drives the regfile write port. Keeps a per-register
//  pending-write scoreboard that decode queries for RAW/WAW stalls.
// PARAMETERS
//  XLEN   64  data width of results and regfile entries
//  NREG   32  number of architectural registers (address width 5)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     synchronous reset, active-high
//  alu_valid    in   1     ALU result available
//  alu_ready    out  1     ALU result accepted this cycle (valid&ready)
//  alu_rd       in   5     ALU destination register
//  alu_data     in   XLEN  ALU result
//  mem_valid    in   1     load result available
//  mem_ready    out  1     load result accepted this cycle
//  mem_rd       in   5     load destination register
//  mem_data     in   XLEN  load result (already extended)
//  iss_valid    in   1     decode issues an instr that writes iss_rd
//  iss_rd       in   5     destination of issuing instr
//  q_rs1        in   5     decode source 1 query
//  q_rs2        in   5     decode source 2 query
//  q_rd         in   5     decode destination query
//  iss_stall    out  1     issue must not occur this cycle (hazard)
//  wen_REGS     out  1     regfile write enable
//  aind_REGS    out  5     regfile write address
//  din_REGS     out  XLEN  regfile write data
//  wb_count     out  64    number of results retired since reset
//  err_waw      out  1     sticky: issue occurred while iss_stall was high
// BEHAVIOUR
//  - Reset: wen_REGS=0, aind_REGS=0, din_REGS=0, scoreboard all 0, wb_count=0,
//    err_waw=0, rr_last=ALU (so first conflict grants MEM).
//  - At most one source accepted per cycle. Only one valid -> it wins.
//    Both valid -> round-robin: grant the source not granted at the last
//    conflict; rr_last updates only on conflict cycles.
//  - Ready is combinational: winner sees ready=1, loser ready=0; no valid -> 0.
//    Sources hold rd/data stable while valid&!ready.
//  - Latency 1: result accepted in cycle N appears on *_REGS in cycle N+1 with
//    wen_REGS=1 for exactly one cycle; no accept in N -> wen_REGS=0 in N+1.
//    aind/din hold last value when wen_REGS=0.
//  - x0: a result with rd=0 is accepted and counted but produces wen_REGS=0.
//  - Scoreboard busy[31:0]: set on iss_valid for iss_rd!=0; cleared for
//    aind_REGS on the cycle wen_REGS=1. busy[0] is constant 0.
//  - Effective busy for queries = busy & ~clear_mask (write landing this cycle
//    is visible to REGS reads next cycle, same as stall release).
//    iss_stall = eff[q_rs1] | eff[q_rs2] | eff[q_rd].
//  - Same-cycle set and clear of one rd: set wins (bit stays 1).
//  - iss_valid while iss_stall=1: still sets busy, err_waw latches 1 until rst.
//  - wb_count increments by 1 each cycle a result is accepted (incl. rd=0);
//    wraps at 2^64.
//  - rst mid-operation: in-flight registered result dropped (wen_REGS=0 next
//    cycle), scoreboard and counters cleared; sources see ready=0 during rst.
// TESTING
//  - Reset: rst=1 2 cycles -> wen_REGS=0, iss_stall=0, wb_count=0, err_waw=0.
//  - ALU only: alu rd=5 data=0x1234 valid 1 cycle -> alu_ready=1 same cycle;
//    next cycle wen_REGS=1, aind=5, din=0x1234; wb_count=1.
//  - Conflict: alu rd=3 and mem rd=4 both valid 2 cycles -> MEM granted first,
//    ALU second; writes to 4 then 3 on consecutive cycles.
//  - Scoreboard: issue rd=7, then q_rs1=7 -> iss_stall=1 until ALU rd=7 result
//    drives wen_REGS; stall=0 in that same cycle; issue rd=7 then also sets.
//  - x0: mem rd=0 data=0xFFFF -> mem_ready=1, wen_REGS stays 0, wb_count+1,
//    q_rs2=0 never stalls.
//  - WAW error: issue rd=9 twice with no writeback -> iss_stall=1 on second,
//    err_waw=1 sticky until rst.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU and load results into the regfile write port
// and tracks pending register writes for decode hazard checks.
module wb_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    input  logic [4:0]      q_rd,
    output logic            iss_stall,
    output logic            wen_REGS,
    output logic [4:0]      aind_REGS,
    output logic [XLEN-1:0] din_REGS,
    output logic [63:0]     wb_count,
    output logic            err_waw
);

    // rr_last_reg: 0 = ALU won the last conflict, 1 = MEM won it
    logic            rr_last_reg;
    logic            wen_reg;
    logic [4:0]      aind_reg;
    logic [XLEN-1:0] din_reg;
    logic [63:0]     count_reg;
    logic            err_reg;
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] clear_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] eff_busy;

    logic            grant_alu;
    logic            grant_mem;
    logic            accept;
    logic            conflict;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        conflict  = alu_valid && mem_valid;
        if (!rst) begin
            grant_alu = alu_valid && (!mem_valid || rr_last_reg);
            grant_mem = mem_valid && (!alu_valid || !rr_last_reg);
        end
        if (grant_mem) begin
            win_rd   = mem_rd;
            win_data = mem_data;
        end else if (grant_alu) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end
        accept = grant_alu || grant_mem;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // A write landing this cycle already releases its register for queries;
    // a same-cycle issue to the same register re-arms the bit.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            assign clear_mask[gi] = wen_reg && (aind_reg == 5'(gi));
            assign eff_busy[gi]   = busy_reg[gi] && !clear_mask[gi];
            if (gi == 0) begin : g_x0
                assign set_mask[gi]  = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign set_mask[gi]  = iss_valid && (iss_rd == 5'(gi));
                assign busy_next[gi] = eff_busy[gi] || set_mask[gi];
            end
        end
    endgenerate

    assign iss_stall = eff_busy[q_rs1] | eff_busy[q_rs2] | eff_busy[q_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_reg <= 1'b0;
            wen_reg     <= 1'b0;
            aind_reg    <= '0;
            din_reg     <= '0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= '0;
        end else begin
            wen_reg  <= accept && (win_rd != 5'd0);
            busy_reg <= busy_next;
            if (accept && (win_rd != 5'd0)) begin
                aind_reg <= win_rd;
                din_reg  <= win_data;
            end
            if (accept) begin
                count_reg <= count_reg + 64'd1;
            end
            if (conflict) begin
                rr_last_reg <= grant_mem;
            end
            if (iss_valid && iss_stall) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign wen_REGS  = wen_reg;
    assign aind_REGS = aind_reg;
    assign din_REGS  = din_reg;
    assign wb_count  = count_reg;
    assign err_waw   = err_reg;

endmodule
